// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory fetch/data arbiter.
package mem_arb_pkg;

  // Names which requester, if any, is waiting for read data this cycle.
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DM   = 2'd2
  } resp_owner_e;

  localparam int          STREAK_W  = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0100_0000;

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bundles the fetch port, data port and memory-side port of the arbiter.
interface imem_dmem_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  // Handshake: a request is accepted in the cycle where req and gnt are both
  // high. The requester holds req and its payload until it sees gnt. Read data
  // comes back exactly one cycle after the accepting cycle, flagged by rvalid,
  // with no back-pressure on the response side.
  logic              if_req_i;
  logic [AWIDTH-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DWIDTH-1:0] if_rdata_o;
  logic              flush_i;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [AWIDTH-1:0] dm_addr_i;
  logic [DWIDTH-1:0] dm_wdata_i;
  logic              dm_gnt_o;
  logic              dm_rvalid_o;
  logic [DWIDTH-1:0] dm_rdata_o;

  logic [AWIDTH-1:0] mem_addr_o;
  logic [DWIDTH-1:0] mem_data_o;
  logic              mem_read_en_o;
  logic              mem_write_en_o;
  logic [DWIDTH-1:0] mem_data_i;

  modport slave (
    input  if_req_i, if_addr_i, flush_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_data_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
  );

  modport master (
    output if_req_i, if_addr_i, flush_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_data_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Two-requester priority with data preferred and a bounded-starvation
// override for fetch; reusable for other two-way memory arbiters.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic                enable,
  input  logic                if_req,
  input  logic                dm_req,
  input  logic [STREAK_W-1:0] streak_q,
  output logic                if_gnt,
  output logic                dm_gnt,
  output logic [STREAK_W-1:0] streak_d
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

  always_comb begin
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    streak_d = '0;
    if (enable) begin
      if (if_req && dm_req) begin
        // Reaching LIMIT hands the next contended cycle to fetch, so the
        // counter never climbs past LIMIT.
        if (streak_q == LIMIT) begin
          if_gnt = 1'b1;
        end else begin
          dm_gnt   = 1'b1;
          streak_d = streak_q + STREAK_W'(1);
        end
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// the load/store path, and steers each read response back to its issuer.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  imem_dmem_arbiter_if.slave  bus,
  output resp_owner_e         resp_state,
  output logic [STREAK_W-1:0] streak
);

  resp_owner_e         resp_q, resp_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                if_gnt, dm_gnt;

  // Gating with ~rst keeps every combinational output at zero during reset.
  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .enable   (~rst),
    .if_req   (bus.if_req_i),
    .dm_req   (bus.dm_req_i),
    .streak_q (streak_q),
    .if_gnt   (if_gnt),
    .dm_gnt   (dm_gnt),
    .streak_d (streak_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q   <= RESP_NONE;
      streak_q <= '0;
    end else begin
      resp_q   <= resp_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    resp_d = RESP_NONE;
    if (if_gnt) begin
      resp_d = RESP_IF;
    end else if (dm_gnt && !bus.dm_we_i) begin
      resp_d = RESP_DM;
    end
  end

  always_comb begin
    bus.if_gnt_o       = if_gnt;
    bus.dm_gnt_o       = dm_gnt;
    bus.mem_addr_o     = '0;
    bus.mem_data_o     = '0;
    bus.mem_read_en_o  = 1'b0;
    bus.mem_write_en_o = 1'b0;
    if (if_gnt) begin
      bus.mem_addr_o    = bus.if_addr_i;
      bus.mem_read_en_o = 1'b1;
    end else if (dm_gnt) begin
      bus.mem_addr_o     = bus.dm_addr_i;
      bus.mem_data_o     = bus.dm_wdata_i;
      bus.mem_read_en_o  = ~bus.dm_we_i;
      bus.mem_write_en_o = bus.dm_we_i;
    end
  end

  // A redirect discards only the fetch word arriving now; data is unaffected.
  always_comb begin
    bus.if_rvalid_o = (resp_q == RESP_IF) && !bus.flush_i;
    bus.dm_rvalid_o = (resp_q == RESP_DM);
    bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_data_i : '0;
    bus.dm_rdata_o  = bus.dm_rvalid_o ? bus.mem_data_i : '0;
  end

  assign resp_state = resp_q;
  assign streak     = streak_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed, table-driven bench for imem_dmem_arbiter with a one-cycle memory.
module tb_imem_dmem_arbiter;
  import mem_arb_pkg::*;

  localparam logic [1:0] GN = 2'd0, GI = 2'd1, GD = 2'd2;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  gnt;
    logic        if_rv;
    logic [31:0] if_rd;
    logic        dm_rv;
    logic [31:0] dm_rd;
    logic [3:0]  streak;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  resp_owner_e         resp_state;
  logic [STREAK_W-1:0] streak;
  int checks = 0;
  int passes = 0;
  vec_t vecs[$];

  logic [31:0] mem [0:255];
  logic [31:0] mem_rdata = '0;

  imem_dmem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  imem_dmem_arbiter #(
    .AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .resp_state (resp_state),
    .streak     (streak)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  assign bus.mem_data_i = mem_rdata;

  always @(posedge clk) begin
    if (bus.mem_write_en_o) mem[bus.mem_addr_o[9:2]] <= bus.mem_data_o;
    if (bus.mem_read_en_o)  mem_rdata <= mem[bus.mem_addr_o[9:2]];
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic fl,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dd);
    bus.if_req_i   = ir;
    bus.if_addr_i  = ia;
    bus.flush_i    = fl;
    bus.dm_req_i   = dr;
    bus.dm_we_i    = dw;
    bus.dm_addr_i  = da;
    bus.dm_wdata_i = dd;
  endtask

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic fl,
                              input logic dr, input logic dw, input logic [31:0] da,
                              input logic [31:0] dd, input logic [1:0] g,
                              input logic irv, input logic [31:0] ird,
                              input logic drv, input logic [31:0] drd,
                              input logic [3:0] st);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.flush = fl;
    v.dm_req = dr; v.dm_we = dw; v.dm_addr = da; v.dm_wdata = dd;
    v.gnt = g; v.if_rv = irv; v.if_rd = ird; v.dm_rv = drv; v.dm_rd = drd;
    v.streak = st;
    return v;
  endfunction

  task automatic apply_row(input vec_t v, input int idx);
    logic [31:0] e_addr, e_data;
    logic e_re, e_we;
    @(negedge clk);
    drive(v.if_req, v.if_addr, v.flush, v.dm_req, v.dm_we, v.dm_addr, v.dm_wdata);
    #1;
    e_addr = '0; e_data = '0; e_re = 1'b0; e_we = 1'b0;
    if (v.gnt == GI) begin
      e_addr = v.if_addr; e_re = 1'b1;
    end else if (v.gnt == GD) begin
      e_addr = v.dm_addr; e_data = v.dm_wdata; e_re = !v.dm_we; e_we = v.dm_we;
    end
    check($sformatf("row%0d if_gnt", idx),    32'(bus.if_gnt_o),       32'(v.gnt == GI));
    check($sformatf("row%0d dm_gnt", idx),    32'(bus.dm_gnt_o),       32'(v.gnt == GD));
    check($sformatf("row%0d mem_addr", idx),  bus.mem_addr_o,          e_addr);
    check($sformatf("row%0d mem_data", idx),  bus.mem_data_o,          e_data);
    check($sformatf("row%0d mem_re", idx),    32'(bus.mem_read_en_o),  32'(e_re));
    check($sformatf("row%0d mem_we", idx),    32'(bus.mem_write_en_o), 32'(e_we));
    check($sformatf("row%0d if_rvalid", idx), 32'(bus.if_rvalid_o),    32'(v.if_rv));
    check($sformatf("row%0d if_rdata", idx),  bus.if_rdata_o,          v.if_rd);
    check($sformatf("row%0d dm_rvalid", idx), 32'(bus.dm_rvalid_o),    32'(v.dm_rv));
    check($sformatf("row%0d dm_rdata", idx),  bus.dm_rdata_o,          v.dm_rd);
    check($sformatf("row%0d streak", idx),    32'(streak),             32'(v.streak));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " if_gnt"},    32'(bus.if_gnt_o),       32'd0);
    check({tag, " dm_gnt"},    32'(bus.dm_gnt_o),       32'd0);
    check({tag, " mem_addr"},  bus.mem_addr_o,          32'd0);
    check({tag, " mem_re"},    32'(bus.mem_read_en_o),  32'd0);
    check({tag, " mem_we"},    32'(bus.mem_write_en_o), 32'd0);
    check({tag, " dm_rvalid"}, 32'(bus.dm_rvalid_o),    32'd0);
    check({tag, " dm_rdata"},  bus.dm_rdata_o,          32'd0);
    check({tag, " if_rvalid"}, 32'(bus.if_rvalid_o),    32'd0);
    check({tag, " streak"},    32'(streak),             32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a04, a08, a0c, a10, a14, a100;
    logic [1:0]  seq [0:3];
    a04 = BASE_ADDR + 32'h4;   a08 = BASE_ADDR + 32'h8;  a0c = BASE_ADDR + 32'hC;
    a10 = BASE_ADDR + 32'h10;  a14 = BASE_ADDR + 32'h14; a100 = BASE_ADDR + 32'h100;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i);

    // Reset with both requests high: everything must stay zero.
    drive(1'b1, a04, 1'b0, 1'b1, 1'b0, a10, 32'h0);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;

    // fetch-only stream
    vecs.push_back(mk(1, a04, 0, 0, 0, 0, 0, GI, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, a08, 0, 0, 0, 0, 0, GI, 1, 32'hC0DE0001, 0, 0, 0));
    vecs.push_back(mk(1, a0c, 0, 0, 0, 0, 0, GI, 1, 32'hC0DE0002, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0, GN, 1, 32'hC0DE0003, 0, 0, 0));
    // eight contended reads: D,D,D,I,D,D,D,I
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GD, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GD, 0, 0, 1, 32'hC0DE0004, 1));
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GD, 0, 0, 1, 32'hC0DE0004, 2));
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GI, 0, 0, 1, 32'hC0DE0004, 3));
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GD, 1, 32'hC0DE0005, 0, 0, 0));
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GD, 0, 0, 1, 32'hC0DE0004, 1));
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GD, 0, 0, 1, 32'hC0DE0004, 2));
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GI, 0, 0, 1, 32'hC0DE0004, 3));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0, GN, 1, 32'hC0DE0005, 0, 0, 0));
    // write then read back
    vecs.push_back(mk(0, 0, 0, 1, 1, a100, 32'hDEADBEEF, GD, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, a100, 0,            GD, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,    0,            GN, 0, 0, 1, 32'hDEADBEEF, 0));
    // flush drops the in-flight fetch word but not the new grant
    vecs.push_back(mk(1, a04, 0, 0, 0, 0, 0, GI, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, a08, 1, 0, 0, 0, 0, GI, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0, 0, GN, 1, 32'hC0DE0002, 0, 0, 0));
    // flush leaves data responses alone
    vecs.push_back(mk(0, 0, 0, 1, 0, a10, 0, GD, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0,   0, GN, 0, 0, 1, 32'hC0DE0004, 0));
    // an uncontended cycle clears the streak
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GD, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GD, 0, 0, 1, 32'hC0DE0004, 1));
    vecs.push_back(mk(0, 0,   0, 1, 0, a10, 0, GD, 0, 0, 1, 32'hC0DE0004, 2));
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GD, 0, 0, 1, 32'hC0DE0004, 0));
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GD, 0, 0, 1, 32'hC0DE0004, 1));
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GD, 0, 0, 1, 32'hC0DE0004, 2));
    vecs.push_back(mk(1, a14, 0, 1, 0, a10, 0, GI, 0, 0, 1, 32'hC0DE0004, 3));
    vecs.push_back(mk(0, 0,   0, 0, 0, 0,   0, GN, 1, 32'hC0DE0005, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply_row(vecs[i], i);

    // Async reset while a data read is in flight, streak already at 2.
    @(negedge clk);
    drive(1'b1, a14, 1'b0, 1'b1, 1'b0, a10, 32'h0);
    #1 check("pre-rst c1 dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
    @(negedge clk); #1;
    check("pre-rst c2 dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
    check("pre-rst c2 streak", 32'(streak), 32'd1);
    @(negedge clk); #1;
    check("pre-rst c3 dm_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
    check("pre-rst c3 streak", 32'(streak), 32'd2);
    #2 rst = 1'b1;
    #1 check_all_zero("async-rst");
    @(posedge clk); #1;
    check_all_zero("rst-held");
    @(negedge clk);
    rst = 1'b0;
    seq[0] = GD; seq[1] = GD; seq[2] = GD; seq[3] = GI;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("post-rst c%0d if_gnt", k), 32'(bus.if_gnt_o), 32'(seq[k] == GI));
      check($sformatf("post-rst c%0d dm_gnt", k), 32'(bus.dm_gnt_o), 32'(seq[k] == GD));
      check($sformatf("post-rst c%0d dm_rvalid", k), 32'(bus.dm_rvalid_o), 32'(k > 0));
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1 check("final idle if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
    check("final idle if_rdata", bus.if_rdata_o, 32'hC0DE0005);
    @(negedge clk); #1;
    check("final idle streak", 32'(streak), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
